or1200_ld_insn_fifo_ctrl: RTL and testbench
===========================================

OR1200_LD_INSN_FIFO_CTRL -- requirements
Module: or1200_ld_insn_fifo_ctrl

Interface
REQ-001 SHALL have parameter aw, default 4, meaning FIFO address width; depth = 2^aw entries.
REQ-002 SHALL have parameter dw, default 1, meaning tag width per entry (bit0 = secure-load flag).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; all state is cleared while rst=0.
REQ-005 issue_valid  input  1  decoder issues a load this cycle.
REQ-006 issue_tag  input  dw  tag of the issued load.
REQ-007 issue_stall  output  1  decoder must hold its issue; a load is not accepted this cycle.
REQ-008 mem_ack  input  1  one memory data return this cycle, in program order.
REQ-009 pop_valid  output  1  pop_tag is valid for the returned load.
REQ-010 pop_tag  output  dw  tag matching the returned load.
REQ-011 flush  input  1  pipeline flush; discard all outstanding entries.
REQ-012 ram_ce_w  output  1  RAM write enable (port B ce/we).
REQ-013 ram_waddr  output  aw  RAM write address.
REQ-014 ram_din  output  dw  RAM write data.
REQ-015 ram_ce_r  output  1  RAM read enable (port A).
REQ-016 ram_raddr  output  aw  RAM read address.
REQ-017 ram_dout  input  dw  RAM read data, valid one cycle after ram_ce_r.
REQ-018 count  output  aw+1  number of occupied entries, 0..2^aw.
REQ-019 full, empty  output  1 each  count==2^aw, count==0.
REQ-020 underflow_err  output  1  sticky: mem_ack received with nothing to match.

Function
REQ-021 SHALL keep write pointer wptr and read pointer rptr, aw bits each, wrapping modulo 2^aw.
REQ-022 Push: in RUN, issue_valid=1 and full=0 -> ram_ce_w=1, ram_waddr=wptr, ram_din=issue_tag, wptr+1, same cycle (combinational RAM drive).
REQ-023 issue_stall SHALL be full OR (state==DRAIN); ram_ce_w SHALL be 0 whenever issue_stall=1.
REQ-024 Pop: in RUN, mem_ack=1 and empty=0 -> ram_ce_r=1, ram_raddr=rptr, rptr+1; next cycle pop_valid=1, pop_tag=ram_dout (1-cycle latency).
REQ-025 pop_valid SHALL be registered; pop_tag SHALL be 0 when pop_valid=0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push-only +1; pop-only -1.
REQ-027 Push when full SHALL be refused even if mem_ack pops in the same cycle.
REQ-028 mem_ack in RUN with empty=1 SHALL not move rptr, not assert ram_ce_r, and SHALL set underflow_err; no bypass from issue to pop.
REQ-029 FSM states RUN, DRAIN; reset state RUN.
REQ-030 RUN + flush=1: wptr, rptr, count -> 0; drain_cnt <= count - (mem_ack & !empty ? 1 : 0); next state DRAIN if that value >0, else RUN; no push accepted that cycle.
REQ-031 The pop_valid that would follow a pop in the flush cycle SHALL be suppressed.
REQ-032 DRAIN: each mem_ack decrements drain_cnt, no ram_ce_r, no pop_valid; drain_cnt reaching 0 -> RUN the next cycle.
REQ-033 flush in DRAIN SHALL be ignored; mem_ack in DRAIN with drain_cnt==0 is impossible by construction.
REQ-034 drain_cnt SHALL be aw+1 bits.

Reset
REQ-035 rst=0 SHALL force: state RUN, wptr=rptr=0, count=0, drain_cnt=0, empty=1, full=0, pop_valid=0, pop_tag=0, underflow_err=0, issue_stall=0, ram_ce_w=ram_ce_r=0.
REQ-036 rst asserted mid-push/pop or mid-DRAIN SHALL abandon the operation; no pop_valid after rst release until a new push/ack pair.

Verification
REQ-037 Push tags 1,0,1 (aw=4), then 3 mem_ack -> pop_valid on 3 cycles, pop_tag 1,0,1, count 3->0, empty=1.
REQ-038 Push 16 -> full=1, issue_stall=1; 17th issue refused; push+ack same cycle at full -> count 15, wptr unchanged.
REQ-039 Push 20/pop 20 interleaved -> pointers wrap past 15->0, tags returned in order, count never >16.
REQ-040 count=5, flush with no mem_ack -> count 0, DRAIN 5 acks with no pop_valid, issue_stall=1 throughout, RUN after 5th ack.
REQ-041 mem_ack when empty -> underflow_err=1 and stays 1; rptr unchanged; cleared only by rst=0.
REQ-042 rst=0 asserted in DRAIN with drain_cnt=3 -> all outputs at reset values, RUN, immediate push accepted.

Source files
------------

// File: rtl/or1200_ld_insn_fifo_ctrl.sv
// or1200_ld_insn_fifo_ctrl: in-order load tag FIFO controller over an external RAM, with flush drain
module or1200_ld_insn_fifo_ctrl #(
    parameter int aw = 4,
    parameter int dw = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [dw-1:0] issue_tag,
    output logic          issue_stall,
    input  logic          mem_ack,
    output logic          pop_valid,
    output logic [dw-1:0] pop_tag,
    input  logic          flush,
    output logic          ram_ce_w,
    output logic [aw-1:0] ram_waddr,
    output logic [dw-1:0] ram_din,
    output logic          ram_ce_r,
    output logic [aw-1:0] ram_raddr,
    input  logic [dw-1:0] ram_dout,
    output logic [aw:0]   count,
    output logic          full,
    output logic          empty,
    output logic          underflow_err
);
    typedef enum logic {RUN, DRAIN} state_t;
    localparam logic [aw:0] depth = {1'b1, {aw{1'b0}}};
    state_t        state;
    logic [aw-1:0] wptr, rptr;
    logic [aw:0]   drain_cnt, drain_nxt;
    logic          run, push, pop;
    assign run         = rst && state == RUN;
    assign full        = count == depth;
    assign empty       = count == '0;
    assign issue_stall = full || state == DRAIN;
    assign push        = run && issue_valid && !full && !flush;
    assign pop         = run && mem_ack && !empty;
    assign ram_ce_w    = push;
    assign ram_waddr   = wptr;
    assign ram_din     = issue_tag;
    assign ram_ce_r    = pop;
    assign ram_raddr   = rptr;
    assign pop_tag     = pop_valid ? ram_dout : '0;
    assign drain_nxt   = count - (aw+1)'(pop);
    // pointer/occupancy bookkeeping, flush drain FSM and sticky underflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            drain_cnt     <= '0;
            pop_valid     <= 1'b0;
            underflow_err <= 1'b0;
        end else if (state == RUN) begin
            pop_valid <= pop && !flush;
            if (mem_ack && empty) underflow_err <= 1'b1;
            if (flush) begin
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                drain_cnt <= drain_nxt;
                state     <= drain_nxt != '0 ? DRAIN : RUN;
            end else begin
                wptr  <= wptr + aw'(push);
                rptr  <= rptr + aw'(pop);
                count <= count + (aw+1)'(push) - (aw+1)'(pop);
            end
        end else begin
            pop_valid <= 1'b0;
            if (drain_cnt == '0) state <= RUN;
            else if (mem_ack) begin
                drain_cnt <= drain_cnt - (aw+1)'(1);
                state     <= drain_cnt == (aw+1)'(1) ? RUN : DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_or1200_ld_insn_fifo_ctrl.sv
// tb_or1200_ld_insn_fifo_ctrl: randomized scoreboard bench for the load tag FIFO controller
module tb_or1200_ld_insn_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 1;
    localparam int DEPTH = 16;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic [DW-1:0] issue_tag = '0;
    logic          mem_ack = 1'b0;
    logic          flush = 1'b0;
    logic          issue_stall, pop_valid, ram_ce_w, ram_ce_r, full, empty, underflow_err;
    logic [DW-1:0] pop_tag, ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [AW:0]   count;
    logic [DW-1:0] mem [DEPTH];
    int tests = 0;
    int fails = 0;
    int tag_q[$];
    int exp_q[$];
    int drain = 0;
    bit uf = 0;
    int unsigned wcnt = 0;
    int unsigned rcnt = 0;

    or1200_ld_insn_fifo_ctrl #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_stall(issue_stall), .mem_ack(mem_ack), .pop_valid(pop_valid), .pop_tag(pop_tag),
        .flush(flush), .ram_ce_w(ram_ce_w), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_ce_r(ram_ce_r), .ram_raddr(ram_raddr), .ram_dout(ram_dout), .count(count),
        .full(full), .empty(empty), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // external dual-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_ce_w) mem[ram_waddr] <= ram_din;
        if (ram_ce_r) ram_dout <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every returned tag must match the oldest expected one
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("pop_valid", pop_valid, exp_q.size() != 0);
            if (pop_valid && exp_q.size() != 0) chk("pop_tag", pop_tag, exp_q[0]);
            else if (!pop_valid) chk("pop_tag_idle", pop_tag, 0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic step(input bit iv, input bit tg, input bit ak, input bit fl);
        bit st, ps, pp;
        int n;
        @(negedge clk);
        issue_valid = iv;
        issue_tag = tg;
        mem_ack = ak;
        flush = fl;
        #1;
        n = tag_q.size();
        st = (n == DEPTH) || (drain > 0);
        ps = iv && !st && !fl;
        pp = ak && drain == 0 && n > 0;
        chk("issue_stall", issue_stall, st);
        chk("ram_ce_w", ram_ce_w, ps);
        chk("ram_ce_r", ram_ce_r, pp);
        chk("count", count, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("underflow_err", underflow_err, uf);
        if (ps) chk("ram_waddr", ram_waddr, wcnt % DEPTH);
        if (pp) chk("ram_raddr", ram_raddr, rcnt % DEPTH);
        if (drain > 0) begin
            if (ak) drain--;
        end else begin
            if (ak && n == 0) uf = 1;
            if (fl) begin
                drain = n - int'(pp);
                tag_q.delete();
                wcnt = 0;
                rcnt = 0;
            end else begin
                if (pp) begin
                    exp_q.push_back(tag_q.pop_front());
                    rcnt++;
                end
                if (ps) begin
                    tag_q.push_back(tg);
                    wcnt++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b1;
        mem_ack = 1'b1;
        flush = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_tag", pop_tag, 0);
        chk("rst_underflow", underflow_err, 0);
        chk("rst_issue_stall", issue_stall, 0);
        chk("rst_ram_ce_w", ram_ce_w, 0);
        chk("rst_ram_ce_r", ram_ce_r, 0);
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b0;
        mem_ack = 1'b0;
        tag_q.delete();
        exp_q.delete();
        drain = 0;
        uf = 0;
        wcnt = 0;
        rcnt = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, i[0], 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        repeat (15) step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 19; i++) step(1, 1'($urandom), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, i[0], 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, i == 2);
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        do_reset();
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 600 == 0) do_reset();
            else step(1'($urandom), 1'($urandom),
                      (tag_q.size() > 0 || drain > 0) ? 1'($urandom) : ($urandom % 50 == 0),
                      $urandom % 40 == 0);
        end
        for (int k = 0; k < 100 && (tag_q.size() > 0 || drain > 0); k++) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("leftover", tag_q.size() + drain, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
